// File: rtl/door_access_sequencer_pkg.sv
// Shared types and defaults for the door access sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package door_access_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SUBMIT,
    WAIT_RESP,
    UNLOCK,
    RECOVER,
    LOCKOUT
  } state_t;

  localparam int DEF_NUM_READERS    = 2;
  localparam int DEF_RFID_W         = 8;
  localparam int DEF_UNLOCK_CYCLES  = 50;
  localparam int DEF_MAX_FAILS      = 3;
  localparam int DEF_LOCKOUT_CYCLES = 200;
  localparam int DEF_RESP_TIMEOUT   = 8;

  // LSB of reader idx's tag inside the flattened rd_rfid bus.
  function automatic int rfid_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/door_access_sequencer_if.sv
// Reader-side and checker-side signals of the door access sequencer.
// Latency: n/a (wires only).
// Backpressure: readers hold rd_req level until their rd_ack pulse.
interface door_access_sequencer_if #(
  parameter int NUM_READERS = 2,
  parameter int RFID_W      = 8
);
  logic [NUM_READERS-1:0]        rd_req;
  logic [NUM_READERS*RFID_W-1:0] rd_rfid;
  logic [NUM_READERS-1:0]        rd_ack;
  logic                          rd_ok;
  logic                          chk_submit;
  logic [RFID_W-1:0]             chk_rfid;
  logic                          chk_granted;
  logic                          chk_denied;
  logic                          door_unlock;
  logic                          locked_out;
  logic                          alarm;
  logic                          timeout_err;

  modport master (
    input  rd_req, rd_rfid, chk_granted, chk_denied,
    output rd_ack, rd_ok, chk_submit, chk_rfid, door_unlock, locked_out, alarm, timeout_err
  );

  modport slave (
    output rd_req, rd_rfid, chk_granted, chk_denied,
    input  rd_ack, rd_ok, chk_submit, chk_rfid, door_unlock, locked_out, alarm, timeout_err
  );
endinterface

// File: rtl/door_access_sequencer_rr_arbiter.sv
// Round-robin pick: first requesting index at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; caller decides when the pick is consumed.
module rr_arbiter #(
  parameter int NUM_READERS = 2,
  parameter int IDX_W       = $clog2(NUM_READERS)
) (
  input  logic [NUM_READERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   any_grant
);

  always_comb begin : pick
    int cand;
    cand      = 0;
    grant_idx = '0;
    any_grant = 1'b0;
    // Walk from the farthest offset back so the closest requester to ptr wins.
    for (int off = NUM_READERS - 1; off >= 0; off--) begin
      cand = (int'(ptr) + off) % NUM_READERS;
      if (req[cand]) begin
        grant_idx = IDX_W'(cand);
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/door_access_sequencer.sv
// Shares one tag checker between readers: RR pick, submit/response sequencing, strike hold, lockout.
// Latency: req seen -> submit +1, response -> rd_ack +1, door_unlock follows rd_ack by one cycle.
// Backpressure: one transaction at a time; other requests stay pending (and are ignored during lockout).
module door_access_sequencer
  import door_access_sequencer_pkg::*;
#(
  parameter int NUM_READERS    = DEF_NUM_READERS,
  parameter int RFID_W         = DEF_RFID_W,
  parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
  parameter int MAX_FAILS      = DEF_MAX_FAILS,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int RESP_TIMEOUT   = DEF_RESP_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  door_access_sequencer_if.master  bus
);

  localparam int IDX_W  = $clog2(NUM_READERS);
  localparam int WAIT_W = $clog2(RESP_TIMEOUT + 1);
  localparam int UNL_W  = $clog2(UNLOCK_CYCLES + 1);
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam int FAIL_W = $clog2(MAX_FAILS + 1);
  localparam logic [NUM_READERS-1:0] ACK_ONE = NUM_READERS'(1);

  state_t                  state;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        grant_idx;
  logic                    any_grant;
  logic [WAIT_W-1:0]       wait_cnt;
  logic [UNL_W-1:0]        unl_cnt;
  logic [LOCK_W-1:0]       lock_cnt;
  logic [FAIL_W-1:0]       fail_cnt;
  logic [FAIL_W-1:0]       fail_nxt;
  logic [RFID_W-1:0]       tag_q;
  logic [NUM_READERS-1:0]  rd_ack_q;
  logic                    rd_ok_q;
  logic                    submit_q;
  logic                    door_q;
  logic                    locked_q;
  logic                    alarm_q;
  logic                    tmo_q;
  logic                    resp_fail;

  rr_arbiter #(
    .NUM_READERS (NUM_READERS),
    .IDX_W       (IDX_W)
  ) u_arb (
    .req       (bus.rd_req),
    .ptr       (rr_ptr),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign fail_nxt  = (fail_cnt == FAIL_W'(MAX_FAILS)) ? fail_cnt : fail_cnt + FAIL_W'(1);
  // Grant has priority, so a failure is a deny or the last wait cycle without any response.
  assign resp_fail = !bus.chk_granted &&
                     (bus.chk_denied || wait_cnt == WAIT_W'(RESP_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      idx      <= '0;
      wait_cnt <= '0;
      unl_cnt  <= '0;
      lock_cnt <= '0;
      fail_cnt <= '0;
      tag_q    <= '0;
      rd_ack_q <= '0;
      rd_ok_q  <= 1'b0;
      submit_q <= 1'b0;
      door_q   <= 1'b0;
      locked_q <= 1'b0;
      alarm_q  <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      rd_ack_q <= '0;
      rd_ok_q  <= 1'b0;
      submit_q <= 1'b0;
      alarm_q  <= 1'b0;
      tmo_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (any_grant) begin
            idx      <= grant_idx;
            tag_q    <= bus.rd_rfid[rfid_lsb(int'(grant_idx), RFID_W) +: RFID_W];
            submit_q <= 1'b1;
            rr_ptr   <= (grant_idx == IDX_W'(NUM_READERS - 1)) ? '0 : grant_idx + IDX_W'(1);
            state    <= SUBMIT;
          end
        end
        SUBMIT: begin
          wait_cnt <= '0;
          state    <= WAIT_RESP;
        end
        WAIT_RESP: begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
          if (bus.chk_granted) begin
            rd_ack_q <= ACK_ONE << idx;
            rd_ok_q  <= 1'b1;
            fail_cnt <= '0;
            unl_cnt  <= '0;
            state    <= UNLOCK;
          end else if (resp_fail) begin
            rd_ack_q <= ACK_ONE << idx;
            tmo_q    <= !bus.chk_denied;
            fail_cnt <= fail_nxt;
            if (fail_nxt == FAIL_W'(MAX_FAILS)) begin
              alarm_q  <= 1'b1;
              locked_q <= 1'b1;
              lock_cnt <= '0;
              state    <= LOCKOUT;
            end else begin
              state <= RECOVER;
            end
          end
        end
        UNLOCK: begin
          if (unl_cnt == UNL_W'(UNLOCK_CYCLES)) begin
            door_q <= 1'b0;
            state  <= RECOVER;
          end else begin
            door_q  <= 1'b1;
            unl_cnt <= unl_cnt + UNL_W'(1);
          end
        end
        RECOVER: state <= IDLE;
        LOCKOUT: begin
          if (lock_cnt == LOCK_W'(LOCKOUT_CYCLES - 1)) begin
            locked_q <= 1'b0;
            fail_cnt <= '0;
            state    <= IDLE;
          end else begin
            lock_cnt <= lock_cnt + LOCK_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_ack      = rd_ack_q;
  assign bus.rd_ok       = rd_ok_q;
  assign bus.chk_submit  = submit_q;
  assign bus.chk_rfid    = tag_q;
  assign bus.door_unlock = door_q;
  assign bus.locked_out  = locked_q;
  assign bus.alarm       = alarm_q;
  assign bus.timeout_err = tmo_q;

endmodule
